ncl_qadd_sync_bridge: RTL and testbench

//  Clocked test and system interface for the quaternary NCL full adder (one 1-of-4 digit plus a 1-of-2 carry).
//  - Upstream side: accepts binary operands on valid/ready, encodes them as 1-of-4 DATA wavefronts, and drives AQ/BQ/carryin.
//  - Downstream side: sequences the DATA/NULL handshake, synchronises the adder's completion signals and result rails,
//    and returns a binary sum/carry (or an error) on valid/ready.
//  - Sits between the synchronous domain and the adder. It is both the adder's upstream source and its downstream sink.

---
 rtl/ncl_qadd_pkg.sv | 37 +++
 rtl/ncl_sync_vec.sv | 43 ++++
 rtl/ncl_qadd_sync_bridge.sv | 181 ++++++++++++++++++
 tb/tb_ncl_qadd_sync_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_qadd_pkg.sv
// rtl/ncl_qadd_pkg.sv - shared types, rail constants and rail helpers for the NCL adder bridge
package ncl_qadd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        WAITR = 3'd2,
        RNULL = 3'd3,
        OUT   = 3'd4
    } state_e;

    localparam logic [3:0] NULL_Q4 = 4'b0000;
    localparam logic [1:0] NULL_Q2 = 2'b00;

    function automatic logic [3:0] enc_q4(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    // Callers only trust the result when the rails are known one-hot.
    function automatic logic [1:0] dec_q4(input logic [3:0] r);
        case (r)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic onehot_q4(input logic [3:0] r);
        return $countones(r) == 1;
    endfunction

    function automatic logic onehot_q2(input logic [1:0] r);
        return (r == 2'b01) || (r == 2'b10);
    endfunction

endpackage

// File: rtl/ncl_sync_vec.sv
// rtl/ncl_sync_vec.sv - multi-flop synchroniser followed by a consecutive-sample stability filter
module ncl_sync_vec #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q [STABLE_CNT];
    logic [WIDTH-1:0] dout_q;
    logic             stable;

    always_comb begin
        stable = 1'b1;
        for (int i = 1; i < STABLE_CNT; i++) begin
            if (hist_q[i] != hist_q[0]) stable = 1'b0;
        end
    end

    // The filtered value only moves once the whole history agrees, so a rail
    // group caught mid-transition is never presented to the FSM.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int i = 0; i < STABLE_CNT; i++) hist_q[i] <= '0;
            dout_q <= '0;
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q[0] <= sync_q[SYNC_STAGES-1];
            for (int i = 1; i < STABLE_CNT; i++) hist_q[i] <= hist_q[i-1];
            if (stable) dout_q <= hist_q[0];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/ncl_qadd_sync_bridge.sv
// rtl/ncl_qadd_sync_bridge.sv - valid/ready to NCL DATA/NULL bridge for the quaternary full adder
module ncl_qadd_sync_bridge
    import ncl_qadd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       init,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic       in_cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sum,
    output logic       out_cout,
    output logic       out_err,
    output logic [3:0] AQ,
    output logic [3:0] BQ,
    output logic [1:0] carryin,
    input  logic       ABCOMP,
    input  logic [3:0] sumQ,
    input  logic [1:0] carryout,
    output logic       sumCOMP,
    output logic       carryCOMP
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  aq_q, aq_d, bq_q, bq_d;
    logic [1:0]  cin_q, cin_d;
    logic        comp_q, comp_d;
    logic [1:0]  sum_q, sum_d;
    logic        cout_q, cout_d, err_q, err_d, valid_q, valid_d;
    logic        ack_q, ack_d, res_q, res_d, idle_q, idle_d;
    logic [15:0] cnt_q, cnt_d;

    logic        abcomp_s;
    logic [5:0]  rail_s;
    logic [3:0]  sum_s;
    logic [1:0]  cy_s;
    logic        complete, multi, rails_null, timeout_hit, accept, waiting;

    ncl_sync_vec #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CNT(STABLE_CNT)) u_sync_ack (
        .clk(clk), .init(init), .din_i(ABCOMP), .dout_o(abcomp_s)
    );

    ncl_sync_vec #(.WIDTH(6), .SYNC_STAGES(SYNC_STAGES), .STABLE_CNT(STABLE_CNT)) u_sync_res (
        .clk(clk), .init(init), .din_i({sumQ, carryout}), .dout_o(rail_s)
    );

    assign sum_s       = rail_s[5:2];
    assign cy_s        = rail_s[1:0];
    assign complete    = onehot_q4(sum_s) && onehot_q2(cy_s);
    assign multi       = ($countones(sum_s) > 1) || (cy_s == 2'b11);
    assign rails_null  = (sum_s == NULL_Q4) && (cy_s == NULL_Q2);
    assign timeout_hit = (cnt_q == TO_LAST);
    assign accept      = in_valid && in_ready;
    assign waiting     = (state_q == DATA) || (state_q == WAITR) || (state_q == RNULL);

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
            aq_q    <= NULL_Q4;
            bq_q    <= NULL_Q4;
            cin_q   <= NULL_Q2;
            comp_q  <= 1'b0;
            sum_q   <= 2'd0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            res_q   <= 1'b0;
            idle_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            aq_q    <= aq_d;
            bq_q    <= bq_d;
            cin_q   <= cin_d;
            comp_q  <= comp_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            res_q   <= res_d;
            idle_q  <= idle_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aq_d    = aq_q;
        bq_d    = bq_q;
        cin_d   = cin_q;
        comp_d  = comp_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        res_d   = res_q;
        if (waiting && timeout_hit) begin
            // Leave COMP requesting NULL so the adder drains while the error is reported.
            {aq_d, bq_d, cin_d} = {NULL_Q4, NULL_Q4, NULL_Q2};
            {sum_d, cout_d}     = 3'd0;
            err_d   = 1'b1;
            comp_d  = 1'b1;
            valid_d = 1'b1;
            state_d = OUT;
        end else if ((state_q == DATA || state_q == WAITR) && multi) begin
            {aq_d, bq_d, cin_d} = {NULL_Q4, NULL_Q4, NULL_Q2};
            {sum_d, cout_d}     = 3'd0;
            err_d   = 1'b1;
            comp_d  = 1'b1;
            state_d = RNULL;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    aq_d    = enc_q4(in_a);
                    bq_d    = enc_q4(in_b);
                    cin_d   = in_cin ? 2'b10 : 2'b01;
                    {sum_d, cout_d, err_d, comp_d, ack_d, res_d} = '0;
                    state_d = DATA;
                end
                DATA: begin
                    if (abcomp_s) ack_d = 1'b1;
                    if (complete && !res_q) begin
                        res_d  = 1'b1;
                        sum_d  = dec_q4(sum_s);
                        cout_d = cy_s[1];
                    end
                    if (ack_d) begin
                        {aq_d, bq_d, cin_d} = {NULL_Q4, NULL_Q4, NULL_Q2};
                        comp_d  = res_d;
                        state_d = res_d ? RNULL : WAITR;
                    end
                end
                WAITR: if (complete) begin
                    sum_d   = dec_q4(sum_s);
                    cout_d  = cy_s[1];
                    res_d   = 1'b1;
                    comp_d  = 1'b1;
                    state_d = RNULL;
                end
                RNULL: if (!abcomp_s && rails_null) begin
                    comp_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = OUT;
                end
                OUT: if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        idle_d = (state_d == IDLE);
        cnt_d  = (state_d != state_q || !waiting) ? 16'd0 : cnt_q + 16'd1;
    end

    always_comb begin
        in_ready  = idle_q && !abcomp_s;
        out_valid = valid_q;
        out_sum   = sum_q;
        out_cout  = cout_q;
        out_err   = err_q;
        AQ        = aq_q;
        BQ        = bq_q;
        carryin   = cin_q;
        sumCOMP   = comp_q;
        carryCOMP = comp_q;
    end

endmodule

// File: tb/tb_ncl_qadd_sync_bridge.sv
// tb/tb_ncl_qadd_sync_bridge.sv - bench for ncl_qadd_sync_bridge with a behavioural NCL adder model
module tb_ncl_qadd_sync_bridge;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_a = 2'd0;
    logic [1:0] in_b = 2'd0;
    logic       in_cin = 1'b0;
    logic       out_ready = 1'b0;
    logic       ABCOMP = 1'b0;
    logic [3:0] sumQ = 4'd0;
    logic [1:0] carryout = 2'd0;

    logic       in_ready, out_valid, out_cout, out_err, sumCOMP, carryCOMP;
    logic [1:0] out_sum, carryin;
    logic [3:0] AQ, BQ;

    int checks = 0;
    int errors = 0;

    logic       hold_ack = 1'b0;
    logic       bad_rail = 1'b0;
    int         ab_dly = 0;
    int         out_dly = 0;
    logic       pend = 1'b0;
    logic [2:0] pend_val = 3'd0;

    always #5 clk = ~clk;

    ncl_qadd_sync_bridge #(.SYNC_STAGES(2), .STABLE_CNT(2), .TIMEOUT(TO)) dut (
        .clk(clk), .init(init),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .AQ(AQ), .BQ(BQ), .carryin(carryin),
        .ABCOMP(ABCOMP), .sumQ(sumQ), .carryout(carryout),
        .sumCOMP(sumCOMP), .carryCOMP(carryCOMP)
    );

    function automatic int idx4(input logic [3:0] r);
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) if (r[i]) k = i;
        return k;
    endfunction

    // Adder model: input completion follows the operand wavefront, the result
    // is produced once DATA is absorbed and COMP requests DATA, and is cleared
    // when COMP requests NULL. Every transition takes a random 1-20 cycles.
    always @(negedge clk) begin : adder_model
        bit all_data, all_null, want;
        if (init) begin
            ABCOMP = 1'b0; sumQ = 4'd0; carryout = 2'd0;
            ab_dly = 0; out_dly = 0; pend = 1'b0;
        end else begin
            all_data = (AQ != 0) && (BQ != 0) && (carryin != 0);
            all_null = (AQ == 0) && (BQ == 0) && (carryin == 0);
            want = all_data ? 1'b1 : (all_null ? 1'b0 : ABCOMP);
            if (hold_ack) want = 1'b0;
            if (want != ABCOMP) begin
                if (ab_dly == 0) ab_dly = $urandom_range(20, 1);
                else begin
                    ab_dly--;
                    if (ab_dly == 0) begin
                        ABCOMP = want;
                        if (want) begin
                            pend = 1'b1;
                            pend_val = 3'(idx4(AQ) + idx4(BQ) + (carryin[1] ? 1 : 0));
                        end
                    end
                end
            end else ab_dly = 0;
            if (!sumCOMP && pend && sumQ == 0 && carryout == 0) begin
                if (out_dly == 0) out_dly = $urandom_range(20, 1);
                else begin
                    out_dly--;
                    if (out_dly == 0) begin
                        sumQ = bad_rail ? 4'b0011 : (4'b0001 << pend_val[1:0]);
                        carryout = pend_val[2] ? 2'b10 : 2'b01;
                        pend = 1'b0;
                    end
                end
            end else if (sumCOMP && (sumQ != 0 || carryout != 0)) begin
                if (out_dly == 0) out_dly = $urandom_range(20, 1);
                else begin
                    out_dly--;
                    if (out_dly == 0) begin
                        sumQ = 4'd0; carryout = 2'd0;
                    end
                end
            end else out_dly = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal, 1: ABCOMP held low (timeout), 2: multi-hot sum rails
    task automatic run_txn(input logic [1:0] a, input logic [1:0] b, input logic c,
                           input int stall, input int mode, input string tag,
                           output int lat, output int pulses);
        int   n;
        logic prev;
        logic [2:0] s;
        s = 3'(a) + 3'(b) + 3'(c);
        n = 0;
        while (!in_ready && n < 500) begin step(); n++; end
        check({tag, "_in_ready"}, in_ready, 1);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_AQ"}, AQ, 4'b0001 << a);
        check({tag, "_BQ"}, BQ, 4'b0001 << b);
        check({tag, "_carryin"}, carryin, c ? 2'b10 : 2'b01);
        n = 0; pulses = 0; prev = sumCOMP;
        while (!out_valid && n < 1000) begin
            step(); n++;
            if (sumCOMP && !prev) pulses++;
            prev = sumCOMP;
        end
        lat = n;
        check({tag, "_out_valid"}, out_valid, 1);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_a = ~a; in_b = ~b;
            step();
            check({tag, "_stall_in_ready"}, in_ready, 0);
            check({tag, "_stall_out_valid"}, out_valid, 1);
        end
        check({tag, "_out_sum"}, out_sum, mode != 0 ? 2'd0 : s[1:0]);
        check({tag, "_out_cout"}, out_cout, mode != 0 ? 1'b0 : s[2]);
        check({tag, "_out_err"}, out_err, mode != 0);
        check({tag, "_sumCOMP"}, sumCOMP, mode == 1);
        check({tag, "_carryCOMP"}, carryCOMP, mode == 1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_no_accept_in_out"}, AQ, 4'd0);
    endtask

    initial begin : main
        int lat, pulses, seen;
        logic [1:0] ra, rb;
        logic rc;

        init = 1'b1;
        repeat (4) step();
        check("rst_AQ", AQ, 0);
        check("rst_BQ", BQ, 0);
        check("rst_carryin", carryin, 0);
        check("rst_sumCOMP", sumCOMP, 0);
        check("rst_carryCOMP", carryCOMP, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        init = 1'b0;
        step();
        step();
        check("post_rst_in_ready", in_ready, 1);

        run_txn(2'd0, 2'd0, 1'b0, 0, 0, "t1", lat, pulses);
        check("t1_comp_pulses", pulses, 1);
        check("t1_min_latency", lat >= 11, 1);

        run_txn(2'd3, 2'd3, 1'b1, 0, 0, "t2", lat, pulses);
        check("t2_comp_pulses", pulses, 1);

        for (int i = 0; i < 32; i++) begin
            run_txn(2'(i), 2'(i >> 2), 1'(i >> 4), 5, 0, $sformatf("t3_%0d", i), lat, pulses);
        end

        hold_ack = 1'b1;
        run_txn(2'd1, 2'd2, 1'b0, 0, 1, "t4", lat, pulses);
        check("t4_timeout_latency", lat, TO);
        hold_ack = 1'b0;
        run_txn(2'd2, 2'd3, 1'b1, 0, 0, "t4_next", lat, pulses);

        bad_rail = 1'b1;
        run_txn(2'd1, 2'd1, 1'b0, 0, 2, "t5", lat, pulses);
        bad_rail = 1'b0;
        run_txn(2'd3, 2'd0, 1'b1, 0, 0, "t5_next", lat, pulses);

        for (int i = 0; i < 4; i++) begin
            ra = 2'($urandom_range(3, 0));
            rb = 2'($urandom_range(3, 0));
            rc = 1'($urandom_range(1, 0));
            run_txn(ra, rb, rc, $urandom_range(3, 0), 0, $sformatf("rnd_%0d", i), lat, pulses);
        end

        seen = 0;
        while (!in_ready && seen < 500) begin step(); seen++; end
        in_a = 2'd2; in_b = 2'd1; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t6_AQ_data", AQ, 4'b0100);
        repeat (3) step();
        init = 1'b1;
        step();
        check("t6_AQ_null", AQ, 0);
        check("t6_BQ_null", BQ, 0);
        check("t6_carryin_null", carryin, 0);
        check("t6_sumCOMP", sumCOMP, 0);
        repeat (2) step();
        init = 1'b0;
        seen = 0;
        repeat (60) begin
            step();
            if (out_valid) seen++;
        end
        check("t6_no_out_valid", seen, 0);
        run_txn(2'd2, 2'd1, 1'b1, 0, 0, "t6_next", lat, pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
